// File: rtl/encoder_n2m_queue_pkg.sv
// encoder_n2m_queue shared definitions.
// Default index width plus MSB-priority helper functions.
package encoder_pkg;

  localparam int DEF_M = 2;
  localparam int DEF_N = 1 << DEF_M;

  function automatic logic [DEF_M-1:0] msb_index(
    input logic [DEF_N-1:0] v
  );
    logic [DEF_M-1:0] r;
    r = '0;
    for (int i = 0; i < DEF_N; i++) begin
      if (v[i]) r = DEF_M'(i);
    end
    return r;
  endfunction

  function automatic logic [DEF_N-1:0] msb_onehot(
    input logic [DEF_N-1:0] v
  );
    logic [DEF_N-1:0] r;
    r = '0;
    if (|v) r[msb_index(v)] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/encoder_n2m_queue_if.sv
// Request/grant bundle of encoder_n2m_queue.
// master drives en/req/ready; slave (the queue) drives y/valid/pend/ovf/busy.
interface encoder_n2m_queue_if
  import encoder_pkg::*;
#(
  parameter int M = DEF_M
);
  localparam int N = 1 << M;

  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic [M-1:0] y;
  logic         valid;
  logic [N-1:0] pend;
  logic         ovf;
  logic         busy;

  modport master (
    output en, req, ready,
    input  y, valid, pend, ovf, busy
  );

  modport slave (
    input  en, req, ready,
    output y, valid, pend, ovf, busy
  );

endinterface

// File: rtl/encoder_n2m_queue_prio.sv
// Combinational N-to-M priority encoder, highest set index wins.
// in: cand; out: sel (index), sel_oh (one-hot), any (cand nonzero).
module prio_enc_n2m
  import encoder_pkg::*;
#(
  parameter int M = DEF_M
) (
  input  logic [(1<<M)-1:0] cand,
  output logic [M-1:0]      sel,
  output logic [(1<<M)-1:0] sel_oh,
  output logic              any
);

  localparam int N = 1 << M;

  // Ascending scan: the last set bit seen is the MSB.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) sel = M'(i);
    end
  end

  assign any    = |cand;
  assign sel_oh = any ? (N'(1) << sel) : '0;

endmodule

// File: rtl/encoder_n2m_queue.sv
// Sequential priority encoder: captures request events into a pending set
// and issues them one index per cycle over valid/ready. Ports: clk, rst, bus.
module encoder_n2m_queue
  import encoder_pkg::*;
#(
  parameter int M = DEF_M
) (
  input  logic                clk,
  input  logic                rst,
  encoder_n2m_queue_if.slave  bus
);

  localparam int N = 1 << M;

  logic [N-1:0] pend_q;
  logic [M-1:0] y_q;
  logic         valid_q;
  logic         ovf_q;

  logic [N-1:0] new_req;
  logic [N-1:0] cand;
  logic [M-1:0] sel;
  logic [N-1:0] sel_oh;
  logic         any;
  logic         take;

  // New requests bypass straight into selection.
  assign new_req = bus.req & {N{bus.en}};
  assign cand    = pend_q | new_req;
  assign take    = !valid_q || bus.ready;

  prio_enc_n2m #(.M(M)) u_prio (
    .cand   (cand),
    .sel    (sel),
    .sel_oh (sel_oh),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (take) begin
        if (any) begin
          y_q     <= sel;
          valid_q <= 1'b1;
          pend_q  <= cand & ~sel_oh;
        end else begin
          valid_q <= 1'b0;
          pend_q  <= '0;
        end
      end else begin
        pend_q <= cand;
      end
      // A re-request of the index held in y is a fresh entry, not a merge.
      if (|(new_req & pend_q)) ovf_q <= 1'b1;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = valid_q | (|pend_q);

endmodule

// File: tb/tb_encoder_n2m_queue.sv
// Directed vector bench for encoder_n2m_queue (M=2).
// Per-cycle table plus a hand-written async reset sequence.
module tb_encoder_n2m_queue;

  localparam int M = 2;
  localparam int N = 4;

  logic clk;
  logic rst;

  encoder_n2m_queue_if #(.M(M)) bus ();

  encoder_n2m_queue #(.M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         en;
    logic [N-1:0] req;
    logic         ready;
    logic [M-1:0] y;
    logic         valid;
    logic [N-1:0] pend;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];
  int checks;
  int errors;

  task automatic add(
    input string        nm,
    input logic         en,
    input logic [N-1:0] req,
    input logic         rdy,
    input logic [M-1:0] y,
    input logic         v,
    input logic [N-1:0] p,
    input logic         o
  );
    vec_t t;
    t.name = nm; t.en = en; t.req = req; t.ready = rdy;
    t.y = y; t.valid = v; t.pend = p; t.ovf = o;
    vecs.push_back(t);
  endtask

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(
    input string        nm,
    input logic [M-1:0] y,
    input logic         v,
    input logic [N-1:0] p,
    input logic         o
  );
    chk({nm, ".y"}, int'(bus.y), int'(y));
    chk({nm, ".valid"}, int'(bus.valid), int'(v));
    chk({nm, ".pend"}, int'(bus.pend), int'(p));
    chk({nm, ".ovf"}, int'(bus.ovf), int'(o));
    chk({nm, ".busy"}, int'(bus.busy), int'(v | (|p)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req = '0;
    bus.ready = 1'b0;

    //  name      en req      rdy y  v p        o
    add("single",  1, 4'b0100, 1, 2, 1, 4'b0000, 0);
    add("single2", 1, 4'b0000, 1, 2, 0, 4'b0000, 0);
    add("reidx0",  1, 4'b0100, 0, 2, 1, 4'b0000, 0);
    add("reidx1",  1, 4'b0100, 0, 2, 1, 4'b0100, 0);
    add("reidx2",  1, 4'b0000, 1, 2, 1, 4'b0000, 0);
    add("reidx3",  1, 4'b0000, 1, 2, 0, 4'b0000, 0);
    add("burst0",  1, 4'b1011, 1, 3, 1, 4'b0011, 0);
    add("burst1",  1, 4'b0000, 1, 1, 1, 4'b0001, 0);
    add("burst2",  1, 4'b0000, 1, 0, 1, 4'b0000, 0);
    add("burst3",  1, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add("bp0",     1, 4'b0101, 0, 2, 1, 4'b0001, 0);
    add("bp1",     1, 4'b0000, 0, 2, 1, 4'b0001, 0);
    add("bp2",     1, 4'b0000, 0, 2, 1, 4'b0001, 0);
    add("ovf",     1, 4'b0001, 0, 2, 1, 4'b0001, 1);
    add("otake",   1, 4'b1000, 0, 2, 1, 4'b1001, 1);
    add("rel0",    1, 4'b0000, 1, 3, 1, 4'b0001, 1);
    add("rel1",    1, 4'b0000, 1, 0, 1, 4'b0000, 1);
    add("rel2",    1, 4'b0000, 1, 0, 0, 4'b0000, 1);
    add("engate0", 1, 4'b0110, 0, 2, 1, 4'b0010, 1);
    add("engate1", 0, 4'b1111, 1, 1, 1, 4'b0000, 1);
    add("engate2", 0, 4'b1111, 1, 1, 0, 4'b0000, 1);
    add("engate3", 0, 4'b1111, 1, 1, 0, 4'b0000, 1);

    step();
    chk_all("reset", 2'd0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    chk_all("idle", 2'd0, 1'b0, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      bus.en    = vecs[i].en;
      bus.req   = vecs[i].req;
      bus.ready = vecs[i].ready;
      step();
      chk_all(vecs[i].name, vecs[i].y, vecs[i].valid,
              vecs[i].pend, vecs[i].ovf);
    end

    // Mid-operation asynchronous reset.
    bus.en = 1'b1;
    bus.req = 4'b1011;
    bus.ready = 1'b0;
    step();
    chk_all("prerst", 2'd3, 1'b1, 4'b0011, 1'b1);
    bus.req = '0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("asyncrst", 2'd0, 1'b0, 4'b0000, 1'b0);
    #1;
    rst = 1'b0;
    bus.req = 4'b0010;
    bus.ready = 1'b1;
    step();
    chk_all("postrst", 2'd1, 1'b1, 4'b0000, 1'b0);
    bus.req = '0;
    step();
    chk_all("postrst2", 2'd1, 1'b0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
